alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Registered ALU operand-select stage between ID and EX.
- Builds operand A from {0, rs1, pc} and operand B from {0, rs2, imm, 4}.
- rs1 and rs2 are overridden by EX/MEM forwarding.
- Holds the result in a valid/ready pipeline buffer, optionally a 2-entry skid; the buffer also keeps a saturating backpressure counter.

Parameters:
- XLEN, 64, operand/data width in bits.
- SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single register (in_ready = out_ready | ~out_valid).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream operand request valid.
- in_ready  out  1  stage can accept this cycle.
- asel  in  2  A select: 00 zero, 01 rs1, 10 pc, 11 zero.
- bsel  in  2  B select: 00 zero, 01 rs2, 10 imm, 11 constant 4.
- rs1, rs2, pc, imm  in  XLEN each  raw sources.
- fwd_a, fwd_b  in  2 each  forwarding: 00 none, 01 EX, 10 MEM, 11 none.
- ex_result, mem_result  in  XLEN each  bypass values.
- out_valid  out  1  operands valid.
- out_ready  in  1  EX consumes when out_valid & out_ready.
- a_out, b_out  out  XLEN each  registered operands.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & ~out_ready.

Behaviour:
- Reset (rstn low, async): state EMPTY; out_valid = 0; a_out = b_out = 0; stall_cnt = 0; skid entry cleared.
- in_ready after reset is 1.
- Operand forming is combinational at accept time.
  - Forwarding replaces rs1 only when asel = 01, and rs2 only when bsel = 01.
  - fwd 01 selects ex_result; fwd 10 selects mem_result.
  - Forwarding is ignored for the pc, imm, zero and 4 selects.
  - Constant 4 is zero-extended to XLEN.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: accepted operands appear on a_out/b_out the next cycle with out_valid = 1.
- State machine (SKID = 1):
  - EMPTY: accept -> BUSY (main loads new).
  - BUSY: pop & ~accept -> EMPTY; accept & pop -> BUSY (main loads new); accept & ~pop -> FULL (skid loads new, main held).
  - FULL: in_ready = 0; pop -> BUSY (main <= skid); ~pop -> FULL (hold).
- in_ready = (state != FULL), driven from a register; no combinational path from out_ready.
- SKID = 0: states EMPTY/BUSY only; in_ready = out_ready | ~out_valid; accept in BUSY requires a same-cycle pop.
- a_out/b_out are stable while out_valid & ~out_ready; data is never dropped or duplicated.
- flush has priority over everything:
  - next state EMPTY and out_valid = 0.
  - Any same-cycle accept is discarded.
  - a_out/b_out hold their last values (don't-care).
  - stall_cnt is unaffected.
- stall_cnt increments each cycle out_valid & ~out_ready and saturates at 2^CNT_W-1. Only reset clears it.
- Reset mid-operation: all entries lost immediately; no output glitch requirement beyond the async clear.

Decomposition:
- Shared package alu_pkg holds:
  - ASEL_ZERO/RS1/PC and BSEL_ZERO/RS2/IMM/FOUR encodings.
  - FWD_NONE/EX/MEM encodings.
  - The buffer state enum {EMPTY, BUSY, FULL}.
- One natural sub-module: operand_fwd_mux, purely combinational (sel, fwd, raw, ex, mem -> XLEN value), instanced twice for A and B. Generalises the old A-only mux.
- The buffer/FSM and stall counter stay in the top.

Test Plan:
- Basic select: asel=01 rs1=0x10, bsel=10 imm=0xFFFF_FFFF_FFFF_FFF8, fwd=00, out_ready=1 -> next cycle a_out=0x10, b_out=0xFFFF_FFFF_FFFF_FFF8, out_valid=1.
- Forwarding priority and scope:
  - asel=01 fwd_a=01 ex_result=0xAA -> a_out=0xAA.
  - fwd_a=10 mem_result=0xBB -> a_out=0xBB.
  - asel=10 pc=0x8000_0000 fwd_a=01 -> a_out=0x8000_0000 (forwarding ignored).
- JAL link: asel=10 pc=0x1000, bsel=11 -> a_out=0x1000, b_out=4.
- Skid backpressure (SKID=1): out_ready=0, send ops X then Y.
  - in_ready drops to 0 after Y is accepted; stall_cnt counts each held cycle.
  - Raise out_ready -> X then Y popped in order, nothing lost; in_ready returns to 1.
- Flush in FULL with in_valid=1 (op Z) -> next cycle out_valid=0, in_ready=1, Z never appears; stall_cnt unchanged.
- Async reset asserted mid-BUSY between clock edges -> out_valid, a_out, b_out, stall_cnt go to 0 immediately. Saturation with CNT_W=4: 20 stalled cycles -> stall_cnt=15.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand-select stage: source selects,
// forwarding selects and the operand buffer state.
package alu_pkg;

    // Operand A source select; 2'b11 also yields zero
    localparam logic [1:0] ASEL_ZERO = 2'b00;
    localparam logic [1:0] ASEL_RS1  = 2'b01;
    localparam logic [1:0] ASEL_PC   = 2'b10;

    // Operand B source select
    localparam logic [1:0] BSEL_ZERO = 2'b00;
    localparam logic [1:0] BSEL_RS2  = 2'b01;
    localparam logic [1:0] BSEL_IMM  = 2'b10;
    localparam logic [1:0] BSEL_FOUR = 2'b11;

    // Register-operand forwarding source; 2'b11 also means no forwarding
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Occupancy of the output buffer: FULL means the skid entry is in use
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } buf_state_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational operand source mux with EX/MEM forwarding on the register
// source. Select codes 00/01/10 mean zero/register/alternate for both A and
// B; code 11 gives the constant 4 when FOUR_EN is set and zero otherwise.
module operand_fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter bit FOUR_EN = 1'b1
) (
    input  logic [1:0]      sel,
    input  logic [1:0]      fwd,
    input  logic [XLEN-1:0] raw_reg,
    input  logic [XLEN-1:0] raw_alt,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] reg_val;

    // Forwarding only ever replaces the register source, never pc/imm/constants
    always_comb begin
        reg_val = raw_reg;
        case (fwd)
            FWD_EX:  reg_val = ex_result;
            FWD_MEM: reg_val = mem_result;
            default: reg_val = raw_reg;
        endcase
    end

    // Pick the operand source; A and B share the 00/01/10 encodings
    always_comb begin
        value = '0;
        case (sel)
            BSEL_RS2:  value = reg_val;
            BSEL_IMM:  value = raw_alt;
            BSEL_FOUR: value = FOUR_EN ? XLEN'(4) : '0;
            default:   value = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage between ID and EX. Operands are formed
// combinationally at accept time and held in a valid/ready buffer, either a
// two-entry skid (registered in_ready) or a single register. A saturating
// counter records cycles where EX applies backpressure.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       asel,
    input  logic [1:0]       bsel,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [XLEN-1:0]  mem_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  a_out,
    output logic [XLEN-1:0]  b_out,
    output logic [CNT_W-1:0] stall_cnt
);

    buf_state_t       state_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  skid_a_q;
    logic [XLEN-1:0]  skid_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  a_new;
    logic [XLEN-1:0]  b_new;
    logic             accept;
    logic             pop;

    operand_fwd_mux #(
        .XLEN    (XLEN),
        .FOUR_EN (1'b0)
    ) u_mux_a (
        .sel        (asel),
        .fwd        (fwd_a),
        .raw_reg    (rs1),
        .raw_alt    (pc),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .value      (a_new)
    );

    operand_fwd_mux #(
        .XLEN    (XLEN),
        .FOUR_EN (1'b1)
    ) u_mux_b (
        .sel        (bsel),
        .fwd        (fwd_b),
        .raw_reg    (rs2),
        .raw_alt    (imm),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .value      (b_new)
    );

    // The skid variant breaks the out_ready -> in_ready path with a register
    assign in_ready  = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid_q);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign stall_cnt = cnt_q;

    // Buffer state machine; flush beats every other transition
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
        end else if (flush) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        a_q         <= a_new;
                        b_q         <= b_new;
                        state_q     <= BUSY;
                        out_valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && pop) begin
                        a_q <= a_new;
                        b_q <= b_new;
                    end else if (accept && (SKID != 0)) begin
                        skid_a_q   <= a_new;
                        skid_b_q   <= b_new;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        a_q        <= skid_a_q;
                        b_q        <= skid_b_q;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating backpressure counter; only reset clears it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (out_valid_q && !out_ready && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a skid instance for the main
// scenarios and a single-register, 4-bit-counter instance for saturation.
module tb_alu_operand_stage;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
    } ops_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        in_valid1;
    logic        out_ready1;
    logic [1:0]  asel, bsel, fwd_a, fwd_b;
    logic [63:0] rs1, rs2, pc, imm, ex_result, mem_result;

    logic        d0_in_ready, d0_out_valid;
    logic [63:0] d0_a, d0_b;
    logic [15:0] d0_stall;
    logic        d1_in_ready, d1_out_valid;
    logic [63:0] d1_a, d1_b;
    logic [3:0]  d1_stall;

    ops_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(64), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(d0_in_ready),
        .asel(asel), .bsel(bsel), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_result(ex_result), .mem_result(mem_result),
        .out_valid(d0_out_valid), .out_ready(out_ready),
        .a_out(d0_a), .b_out(d0_b), .stall_cnt(d0_stall)
    );

    alu_operand_stage #(.XLEN(64), .SKID(0), .CNT_W(4)) dut_sat (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid1), .in_ready(d1_in_ready),
        .asel(asel), .bsel(bsel), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_result(ex_result), .mem_result(mem_result),
        .out_valid(d1_out_valid), .out_ready(out_ready1),
        .a_out(d1_a), .b_out(d1_b), .stall_cnt(d1_stall)
    );

    // Drive one operand request; push the expectation when it will be accepted
    task automatic drive_op(input logic [1:0] as, input logic [1:0] bs,
                            input logic [1:0] fa, input logic [1:0] fb,
                            input logic [63:0] r1, input logic [63:0] r2,
                            input logic [63:0] p, input logic [63:0] im,
                            input logic [63:0] exp_a, input logic [63:0] exp_b,
                            input bit push);
        asel = as; bsel = bs; fwd_a = fa; fwd_b = fb;
        rs1 = r1; rs2 = r2; pc = p; imm = im;
        in_valid = 1'b1;
        if (push) sb.push_back('{a: exp_a, b: exp_b});
    endtask

    // Advance one clock; scoreboard drains whatever the skid DUT pops this cycle
    task automatic cycle();
        ops_t e;
        @(negedge clk);
        if (rstn && d0_out_valid && out_ready && !flush) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL pop_order: popped a=%h b=%h, expected no output", d0_a, d0_b);
            end else begin
                e = sb.pop_front();
                if (d0_a !== e.a || d0_b !== e.b) begin
                    miscompares++;
                    $display("[TB] FAIL pop_data: got a=%h b=%h, expected a=%h b=%h", d0_a, d0_b, e.a, e.b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        out_ready = 1'b1; out_ready1 = 1'b1;
        asel = '0; bsel = '0; fwd_a = '0; fwd_b = '0;
        rs1 = '0; rs2 = '0; pc = '0; imm = '0;
        ex_result = 64'hAA; mem_result = 64'hBB;
        #2;
        vectors++;
        if (d0_out_valid !== 1'b0 || d0_a !== 64'd0 || d0_b !== 64'd0 || d0_stall !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got v=%b a=%h b=%h cnt=%0d, expected all zero", d0_out_valid, d0_a, d0_b, d0_stall);
        end
        vectors++;
        if (d1_out_valid !== 1'b0 || d1_stall !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_sat: got v=%b cnt=%0d, expected 0/0", d1_out_valid, d1_stall);
        end
        #10 rstn = 1'b1;
        cycle();
        vectors++;
        if (d0_in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", d0_in_ready);
        end
    endtask

    task automatic test_basic_select();
        drive_op(2'b01, 2'b10, 2'b00, 2'b00, 64'h10, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8,
                 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        cycle();
        in_valid = 1'b0;
        vectors++;
        if (d0_out_valid !== 1'b1 || d0_a !== 64'h10 || d0_b !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            miscompares++;
            $display("[TB] FAIL basic_select: got v=%b a=%h b=%h, expected 1/10/fffffffffffffff8", d0_out_valid, d0_a, d0_b);
        end
        cycle();
    endtask

    task automatic test_forwarding();
        // rs1 forwarded from EX, rs2 forwarded from MEM
        drive_op(2'b01, 2'b01, 2'b01, 2'b10, 64'h11, 64'h22, 64'h0, 64'h0, 64'hAA, 64'hBB, 1'b1);
        cycle();
        vectors++;
        if (d0_a !== 64'hAA || d0_b !== 64'hBB) begin
            miscompares++;
            $display("[TB] FAIL fwd_ex_mem: got a=%h b=%h, expected aa/bb", d0_a, d0_b);
        end
        // MEM on A; fwd on a zero B select is ignored
        drive_op(2'b01, 2'b00, 2'b10, 2'b01, 64'h11, 64'h22, 64'h0, 64'h0, 64'hBB, 64'h0, 1'b1);
        cycle();
        vectors++;
        if (d0_a !== 64'hBB || d0_b !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL fwd_mem_a: got a=%h b=%h, expected bb/0", d0_a, d0_b);
        end
        // pc and imm selects ignore forwarding
        drive_op(2'b10, 2'b10, 2'b01, 2'b01, 64'h11, 64'h22, 64'h8000_0000, 64'h123,
                 64'h8000_0000, 64'h123, 1'b1);
        cycle();
        vectors++;
        if (d0_a !== 64'h8000_0000 || d0_b !== 64'h123) begin
            miscompares++;
            $display("[TB] FAIL fwd_ignored: got a=%h b=%h, expected 80000000/123", d0_a, d0_b);
        end
        // asel=11 is zero even with forwarding requested
        drive_op(2'b11, 2'b01, 2'b01, 2'b11, 64'h11, 64'h22, 64'h0, 64'h0, 64'h0, 64'h22, 1'b1);
        cycle();
        in_valid = 1'b0;
        vectors++;
        if (d0_a !== 64'h0 || d0_b !== 64'h22) begin
            miscompares++;
            $display("[TB] FAIL asel_11_zero: got a=%h b=%h, expected 0/22", d0_a, d0_b);
        end
        cycle();
    endtask

    task automatic test_jal_link();
        drive_op(2'b10, 2'b11, 2'b00, 2'b01, 64'h0, 64'h77, 64'h1000, 64'h0, 64'h1000, 64'h4, 1'b1);
        cycle();
        in_valid = 1'b0;
        vectors++;
        if (d0_a !== 64'h1000 || d0_b !== 64'h4) begin
            miscompares++;
            $display("[TB] FAIL jal_link: got a=%h b=%h, expected 1000/4", d0_a, d0_b);
        end
        cycle();
    endtask

    task automatic test_skid_backpressure();
        out_ready = 1'b0;
        drive_op(2'b01, 2'b01, 2'b00, 2'b00, 64'hA1, 64'hB1, 64'h0, 64'h0, 64'hA1, 64'hB1, 1'b1);
        cycle();
        vectors++;
        if (d0_out_valid !== 1'b1 || d0_in_ready !== 1'b1 || d0_a !== 64'hA1 || d0_stall !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL skid_first: got v=%b rdy=%b a=%h cnt=%0d, expected 1/1/a1/0", d0_out_valid, d0_in_ready, d0_a, d0_stall);
        end
        drive_op(2'b01, 2'b01, 2'b00, 2'b00, 64'hA2, 64'hB2, 64'h0, 64'h0, 64'hA2, 64'hB2, 1'b1);
        cycle();
        in_valid = 1'b0;
        vectors++;
        if (d0_in_ready !== 1'b0 || d0_a !== 64'hA1 || d0_stall !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL skid_full: got rdy=%b a=%h cnt=%0d, expected 0/a1/1", d0_in_ready, d0_a, d0_stall);
        end
        cycle();
        cycle();
        vectors++;
        if (d0_out_valid !== 1'b1 || d0_a !== 64'hA1 || d0_b !== 64'hB1 || d0_stall !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL skid_hold: got v=%b a=%h b=%h cnt=%0d, expected 1/a1/b1/3", d0_out_valid, d0_a, d0_b, d0_stall);
        end
        out_ready = 1'b1;
        cycle();
        vectors++;
        if (d0_a !== 64'hA2 || d0_in_ready !== 1'b1 || d0_stall !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL skid_drain: got a=%h rdy=%b cnt=%0d, expected a2/1/3", d0_a, d0_in_ready, d0_stall);
        end
        cycle();
        vectors++;
        if (d0_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL skid_empty: got v=%b, expected 0", d0_out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_op(2'b01, 2'b01, 2'b00, 2'b00, 64'hC1, 64'hD1, 64'h0, 64'h0, 64'hC1, 64'hD1, 1'b1);
        cycle();
        drive_op(2'b01, 2'b01, 2'b00, 2'b00, 64'hC2, 64'hD2, 64'h0, 64'h0, 64'hC2, 64'hD2, 1'b1);
        cycle();
        vectors++;
        if (d0_in_ready !== 1'b0 || d0_stall !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL flush_setup: got rdy=%b cnt=%0d, expected 0/4", d0_in_ready, d0_stall);
        end
        // Op Z offered together with flush must vanish
        flush = 1'b1;
        drive_op(2'b01, 2'b01, 2'b00, 2'b00, 64'hEE, 64'hEF, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        // The flush cycle was itself a stalled cycle, so the count moves 4 -> 5 once
        vectors++;
        if (d0_out_valid !== 1'b0 || d0_in_ready !== 1'b1 || d0_stall !== 16'd5) begin
            miscompares++;
            $display("[TB] FAIL flush_kill: got v=%b rdy=%b cnt=%0d, expected 0/1/5", d0_out_valid, d0_in_ready, d0_stall);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        vectors++;
        if (d0_out_valid !== 1'b0 || d0_stall !== 16'd5) begin
            miscompares++;
            $display("[TB] FAIL flush_after: got v=%b cnt=%0d, expected 0/5", d0_out_valid, d0_stall);
        end
        drive_op(2'b10, 2'b11, 2'b00, 2'b00, 64'h0, 64'h0, 64'h2000, 64'h0, 64'h2000, 64'h4, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        int          sent;
        pat  = 16'b1011_0010_1110_0110;
        sent = 0;
        for (int i = 0; i < 16; i++) begin
            out_ready = pat[i];
            if (d0_in_ready && sent < 8) begin
                drive_op(2'b01, 2'b10, 2'b00, 2'b00, 64'hA000 + 64'(sent), 64'h0, 64'h0,
                         64'hB000 + 64'(sent), 64'hA000 + 64'(sent), 64'hB000 + 64'(sent), 1'b1);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        vectors++;
        if (sb.size() != 0 || sent != 8) begin
            miscompares++;
            $display("[TB] FAIL b2b_complete: got pending=%0d sent=%0d, expected 0/8", sb.size(), sent);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_op(2'b01, 2'b01, 2'b00, 2'b00, 64'h99, 64'h98, 64'h0, 64'h0, 64'h99, 64'h98, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        #2 rstn = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if (d0_out_valid !== 1'b0 || d0_a !== 64'd0 || d0_b !== 64'd0 || d0_stall !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v=%b a=%h b=%h cnt=%0d, expected all zero", d0_out_valid, d0_a, d0_b, d0_stall);
        end
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_saturation();
        asel = 2'b01; bsel = 2'b11; fwd_a = 2'b00; fwd_b = 2'b00; rs1 = 64'h55;
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        #1;
        vectors++;
        if (d1_in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_ready_empty: got %b, expected 1", d1_in_ready);
        end
        cycle();
        in_valid1 = 1'b0;
        vectors++;
        if (d1_out_valid !== 1'b1 || d1_a !== 64'h55 || d1_b !== 64'h4 || d1_in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sat_load: got v=%b a=%h b=%h rdy=%b, expected 1/55/4/0", d1_out_valid, d1_a, d1_b, d1_in_ready);
        end
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (i == 15 || i == 20) begin
                vectors++;
                if (d1_stall !== 4'd15) begin
                    miscompares++;
                    $display("[TB] FAIL sat_count_%0d: got %0d, expected 15", i, d1_stall);
                end
            end
        end
        out_ready1 = 1'b1;
        #1;
        vectors++;
        if (d1_in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_ready_comb: got %b, expected 1", d1_in_ready);
        end
        cycle();
        vectors++;
        if (d1_out_valid !== 1'b0 || d1_stall !== 4'd15) begin
            miscompares++;
            $display("[TB] FAIL sat_drain: got v=%b cnt=%0d, expected 0/15", d1_out_valid, d1_stall);
        end
    endtask

    initial begin
        $display("[TB] alu_operand_stage bench start");
        test_reset();
        test_basic_select();
        test_forwarding();
        test_jal_link();
        test_skid_backpressure();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case a scenario wedges the clocked flow
    initial begin
        #20000;
        $display("[TB] FAIL timeout: bench exceeded 20000 time units, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
